// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and the hex glyph table for the seven-segment scan controller.
// Glyphs are stored active-low in {g,f,e,d,c,b,a} order; b and d are lowercase.
package seg_pkg;

    typedef logic [6:0] seg7_t;

    typedef enum logic [1:0] {
        BLANK = 2'd0,
        DEAD  = 2'd1,
        LIT   = 2'd2
    } scan_state_t;

    localparam seg7_t HEX_FONT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    function automatic seg7_t font(logic [3:0] nib);
        return HEX_FONT[nib];
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_dec416.sv
// 4-to-16 one-hot decoder used to pick a glyph row out of the hex font table.
module dec416 (
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);

    always_comb begin
        onehot      = '0;
        onehot[sel] = 1'b1;
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed hex display scanner with a single-entry load buffer and frame-aligned swap.
// Optional build macro: LEADING_ZERO_BLANK_EN (dark slots above the most significant nonzero digit).
//
// state | meaning
// ------+--------------------------------------------------------------
// BLANK | display dark, slot/digit counters held at 0
// DEAD  | start of a slot, anodes off, segments preloaded with the glyph
// LIT   | current digit's anode driven for the rest of the slot
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int DATA_W      = 10,
    parameter int NUM_DIGITS  = 3,
    parameter int REFRESH_DIV = 50000,
    parameter int DEAD_CYC    = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_valid,
    input  logic [DATA_W-1:0]     load_data,
    output logic                  load_ready,
    input  logic                  blank,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam int SLOT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int EXT_W  = 4 * NUM_DIGITS;

    scan_state_t         state, state_nxt;
    logic [SLOT_W-1:0]   slot_cnt;
    logic [IDX_W-1:0]    digit_idx;
    logic [DATA_W-1:0]   disp_reg;
    logic [DATA_W-1:0]   pend_reg;
    logic                pend_full;
    logic [EXT_W-1:0]    disp_ext;
    logic [3:0]          nib;
    logic [15:0]         nib_oh;
    seg7_t               glyph;
    logic                digit_en;
    logic                slot_wrap;
    logic                frame_end;

    assign slot_wrap  = (state != BLANK) && (slot_cnt == SLOT_W'(REFRESH_DIV - 1));
    assign frame_end  = slot_wrap && (digit_idx == IDX_W'(NUM_DIGITS - 1));
    assign load_ready = ~pend_full;

    always_comb begin
        state_nxt = state;
        case (state)
            BLANK: if (!blank) state_nxt = DEAD;
            DEAD: begin
                if (blank)                                     state_nxt = BLANK;
                else if (slot_cnt == SLOT_W'(DEAD_CYC - 1))    state_nxt = LIT;
            end
            LIT: begin
                if (blank)          state_nxt = BLANK;
                else if (slot_wrap) state_nxt = DEAD;
            end
            default: state_nxt = BLANK;
        endcase
    end

    // Counters restart from digit 0 whenever the scan is interrupted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BLANK;
            slot_cnt  <= '0;
            digit_idx <= '0;
        end else begin
            state <= state_nxt;
            if (blank || state == BLANK) begin
                slot_cnt  <= '0;
                digit_idx <= '0;
            end else if (slot_wrap) begin
                slot_cnt  <= '0;
                digit_idx <= (digit_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : digit_idx + 1'b1;
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_reg  <= '0;
            pend_full <= 1'b0;
            disp_reg  <= '0;
        end else begin
            if (load_valid && !pend_full) begin
                pend_reg  <= load_data;
                pend_full <= 1'b1;
            end else if (frame_end && pend_full) begin
                disp_reg  <= pend_reg;
                pend_full <= 1'b0;
            end
        end
    end

    always_comb begin
        disp_ext             = '0;
        disp_ext[DATA_W-1:0] = disp_reg;
    end

    always_comb begin
        nib = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (digit_idx == IDX_W'(i)) nib = disp_ext[4*i +: 4];
        end
    end

    dec416 u_dec416 (
        .sel    (nib),
        .onehot (nib_oh)
    );

    always_comb begin
        glyph = '0;
        for (int k = 0; k < 16; k++) begin
            if (nib_oh[k]) glyph = glyph | HEX_FONT[k];
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msd_idx;

    // Digit 0 is never suppressed, so an all-zero word still shows "0".
    always_comb begin
        msd_idx = '0;
        for (int i = 1; i < NUM_DIGITS; i++) begin
            if (disp_ext[4*i +: 4] != 4'h0) msd_idx = IDX_W'(i);
        end
        digit_en = (digit_idx <= msd_idx);
    end
`else
    assign digit_en = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg <= '1;
            an  <= '1;
        end else begin
            case (state)
                DEAD: begin
                    seg <= glyph;
                    an  <= '1;
                end
                LIT: begin
                    if (digit_en) begin
                        seg <= glyph;
                        an  <= ~(NUM_DIGITS'(1) << digit_idx);
                    end else begin
                        seg <= '1;
                        an  <= '1;
                    end
                end
                default: begin
                    seg <= '1;
                    an  <= '1;
                end
            endcase
        end
    end

endmodule
